// File: rtl/aplic_msi_arbiter.sv
// Round-robin arbiter sharing the APLIC MSI write channel between domains.
// Winner payload is turned into a registered MSI address/data write.
module aplic_msi_arbiter #(
  parameter int unsigned NrDomains = 2,
  parameter int unsigned HartIdxW  = 14,
  parameter int unsigned EiidW     = 11,
  parameter int unsigned DomIdxW   =
    (NrDomains > 1) ? $clog2(NrDomains) : 1
) (
  input  logic                          i_clk,
  input  logic                          ni_rst,
  input  logic [NrDomains-1:0]          i_req_valid,
  output logic [NrDomains-1:0]          o_req_ready,
  input  logic [NrDomains*HartIdxW-1:0] i_req_hart,
  input  logic [NrDomains*EiidW-1:0]    i_req_eiid,
  input  logic [NrDomains*32-1:0]       i_domain_addr,
  input  logic [NrDomains-1:0]          i_domain_en,
  output logic                          o_msi_valid,
  input  logic                          i_msi_ready,
  output logic [31:0]                   o_msi_addr,
  output logic [31:0]                   o_msi_data,
  output logic [DomIdxW-1:0]            o_msi_dom,
  output logic                          o_busy
);

  localparam int unsigned N = NrDomains;

  typedef enum logic {
    Empty,
    Full
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]       elig;
  logic [N-1:0]       gnt;
  logic [2*N-1:0]     elig_dbl;
  logic [N-1:0]       elig_rot;
  logic               any_elig;
  logic               can_load;
  logic               take;
  logic               found;
  logic [DomIdxW-1:0] rr_q, rr_d;
  logic [DomIdxW-1:0] win;
  int unsigned        off;
  int unsigned        wsum;
  int unsigned        nsum;
  logic [31:0]        sel_base;
  logic [31:0]        sel_hart;
  logic [31:0]        sel_eiid;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [DomIdxW-1:0] dom_q, dom_d;

  assign elig     = i_req_valid & i_domain_en;
  assign can_load = (state_q == Empty) | i_msi_ready;
  assign any_elig = |elig;
  assign take     = can_load & any_elig;

  // Rotate so bit 0 is the domain at rr_q; first set bit wins.
  assign elig_dbl = {elig, elig} >> rr_q;
  assign elig_rot = elig_dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    off   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    wsum = 32'(rr_q) + off;
    if (wsum >= N) wsum = wsum - N;
    nsum = wsum + 1;
    if (nsum >= N) nsum = 0;
    win = DomIdxW'(wsum);
  end

  always_comb begin
    sel_base = '0;
    sel_hart = '0;
    sel_eiid = '0;
    gnt      = '0;
    for (int unsigned d = 0; d < N; d++) begin
      if (win == DomIdxW'(d)) begin
        sel_base = i_domain_addr[d*32 +: 32];
        sel_hart = 32'(i_req_hart[d*HartIdxW +: HartIdxW]);
        sel_eiid = 32'(i_req_eiid[d*EiidW +: EiidW]);
        gnt[d]   = take;
      end
    end
  end

  assign o_req_ready = gnt & {N{ni_rst}};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dom_d   = dom_q;
    rr_d    = rr_q;
    if (take) begin
      state_d = Full;
      addr_d  = sel_base + (sel_hart << 12);
      data_d  = sel_eiid;
      dom_d   = win;
      rr_d    = DomIdxW'(nsum);
    end else if (can_load) begin
      state_d = Empty;
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q <= Empty;
      addr_q  <= '0;
      data_q  <= '0;
      dom_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dom_q   <= dom_d;
      rr_q    <= rr_d;
    end
  end

  assign o_msi_valid = (state_q == Full);
  assign o_busy      = o_msi_valid;
  assign o_msi_addr  = addr_q;
  assign o_msi_data  = data_q;
  assign o_msi_dom   = dom_q;

endmodule

// File: doc/aplic_msi_arbiter.md
# aplic_msi_arbiter

Round-robin arbiter that shares the single MSI write channel of the APLIC between all interrupt domains. Each domain raises at most one pending MSI request (target hart index plus EIID). The arbiter forms the MSI address from that domain's configured base `Addr` and presents the result as one registered valid/ready write to the bus-master side. It sits between the per-domain delivery logic and the AXI/bus write adapter.

## Interface
Parameters:
- `NrDomains`, default 2: number of interrupt domains arbitrated; must be ≥ 1.
- `HartIdxW`, default 14: width of the target hart index.
- `EiidW`, default 11: width of the external interrupt identity.
- `DomIdxW`, default `$clog2(NrDomains)` (minimum 1): width of the domain index.

Ports:
- `i_clk` in, 1: clock; all state is rising-edge.
- `ni_rst` in, 1: asynchronous active-low reset.
- `i_req_valid` in, NrDomains: per-domain MSI request pending.
- `o_req_ready` in → out, NrDomains: one-hot acceptance strobe back to the domain.
- `i_req_hart` in, NrDomains*HartIdxW: per-domain target hart index; domain d occupies slice d.
- `i_req_eiid` in, NrDomains*EiidW: per-domain EIID; domain d occupies slice d.
- `i_domain_addr` in, NrDomains*32: per-domain MSI base address (domain config `Addr`).
- `i_domain_en` in, NrDomains: domain MSI delivery enabled (domaincfg IE).
- `o_msi_valid` out, 1: MSI write valid.
- `i_msi_ready` in, 1: MSI write accepted by the bus side.
- `o_msi_addr` out, 32: MSI target address.
- `o_msi_data` out, 32: EIID, zero-extended to 32 bits.
- `o_msi_dom` out, DomIdxW: index of the originating domain.
- `o_busy` out, 1: equals `o_msi_valid`.

## Operation
- Eligibility: `elig[d] = i_req_valid[d] & i_domain_en[d]`. Disabled domains are held off, not dropped; their `o_req_ready` stays 0.
- Output register: `valid_q`, `addr_q`, `data_q`, `dom_q`. Two states:
  - EMPTY: `valid_q` = 0.
  - FULL: `valid_q` = 1.
- `can_load = !valid_q | i_msi_ready`.
- Winner: the first eligible index at or after `rr_q`, searching cyclically (`rr_q`, `rr_q+1`, … mod NrDomains).
- When `can_load` and any `elig`:
  - `o_req_ready[winner]` = 1 (combinational, same cycle). All other `o_req_ready` bits are 0.
  - Next cycle, the output register is loaded and `valid_q` = 1.
  - `rr_q` ← `(winner+1) mod NrDomains`.
- When `can_load` and no `elig`: all `o_req_ready` are 0. If `i_msi_ready` was taken, `valid_q` ← 0.
- When FULL and `!i_msi_ready`: the output register holds and all `o_req_ready` are 0.
- Address: `addr = i_domain_addr[w] + (i_req_hart[w] << 12)`, computed in 32-bit arithmetic. Carry out of bit 31 is discarded (wrap-around).
- Data: `{(32-EiidW)'0, i_req_eiid[w]}`.
- A domain must keep `i_req_valid` and its payload stable until it sees `o_req_ready`. Payload is sampled only in the accept cycle.
- NrDomains = 1: the pointer is constant 0, and the domain is served whenever it is eligible.

## Timing
- Request → `o_msi_valid`: 1 cycle (accept in cycle N, valid in N+1).
- Throughput: one MSI per cycle while `i_msi_ready` = 1. Back-to-back accept occurs in the same cycle as the bus handshake.
- `o_msi_*` are registered. `o_req_ready` is combinational from `i_req_valid`, `i_domain_en`, `rr_q`, `valid_q` and `i_msi_ready`.
- Output stability: while `o_msi_valid & !i_msi_ready`, `o_msi_addr`, `o_msi_data` and `o_msi_dom` must not change.
- Reset (asynchronous, mid-transaction included):
  - `valid_q` = 0, `addr_q` = 0, `data_q` = 0, `dom_q` = 0, `rr_q` = 0.
  - All `o_req_ready` = 0 immediately.
  - An in-flight MSI is abandoned without a handshake.
- Release from reset: the first eligible request is accepted on the first clock edge after `ni_rst` rises.

## Test plan
- Single request:
  - Stimulus: NrDomains = 2; domain 0 requests with base 0x2800_0000, hart 3, EIID 5; `i_msi_ready` = 1.
  - Response: `o_req_ready` = 01 in cycle 0; in cycle 1, `o_msi_valid` = 1, `o_msi_addr` = 0x2800_3000, `o_msi_data` = 0x5, `o_msi_dom` = 0.
- Fairness:
  - Stimulus: both domains request continuously; `i_msi_ready` = 1.
  - Response: grants alternate 0, 1, 0, 1; one MSI every cycle from cycle 1.
- Backpressure:
  - Stimulus: `i_msi_ready` = 0 for 4 cycles after valid is raised.
  - Response: outputs are frozen, all `o_req_ready` = 0; when ready rises, the next request is accepted in that same cycle.
- Disabled domain:
  - Stimulus: `i_domain_en` = 10; both domains request.
  - Response: only domain 1 is served. Domain 0 is held with `o_req_ready` = 0, and is served 1 cycle after its enable is set.
- Address wrap:
  - Stimulus: base 0xFFFF_F000, hart 1.
  - Response: `o_msi_addr` = 0x0000_0000.
- Reset mid-operation:
  - Stimulus: `ni_rst` asserted while `o_msi_valid` = 1 and `i_msi_ready` = 0.
  - Response: `o_msi_valid` drops immediately; after release, arbitration restarts from domain 0.
